// File: rtl/uart_duplex.sv
// rtl/uart_duplex.sv - full-duplex UART, valid/ready Tx and strobed Rx
// Optional even parity on both directions when UART_PARITY_EN is defined.
module uart_duplex #(
    parameter int CLK_DIV   = 104,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic                 tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

    state_t                 tx_state, tx_state_nxt;
    logic [CW-1:0]          tx_cnt, tx_cnt_nxt;
    logic [3:0]             tx_idx, tx_idx_nxt;
    logic [DATA_BITS-1:0]   tx_shift, tx_shift_nxt;
    logic                   tx_nxt;
    logic                   tx_end;

    state_t                 rx_state, rx_state_nxt;
    logic [CW-1:0]          rx_cnt, rx_cnt_nxt;
    logic [3:0]             rx_idx, rx_idx_nxt;
    logic [DATA_BITS-1:0]   rx_shift, rx_shift_nxt, rx_data_nxt;
    logic                   rx_valid_nxt, rx_ferr_nxt;
    logic                   rx_meta, rx_sync, rx_prev;
    logic                   rx_end;

`ifdef UART_PARITY_EN
    logic tx_par, tx_par_nxt;
    logic rx_pacc, rx_pacc_nxt, rx_perr_nxt;
`endif

    assign tx_ready = (tx_state == S_IDLE);

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt + CNT_ONE;
        tx_idx_nxt   = tx_idx;
        tx_shift_nxt = tx_shift;
        tx_nxt       = tx;
`ifdef UART_PARITY_EN
        tx_par_nxt   = tx_par;
`endif
        tx_end       = (tx_cnt == CNT_LAST);
        case (tx_state)
            S_IDLE: begin
                tx_cnt_nxt = '0;
                tx_nxt     = 1'b1;
                if (tx_valid) begin
                    tx_state_nxt = S_START;
                    tx_nxt       = 1'b0;
                    tx_shift_nxt = tx_data;
                    tx_idx_nxt   = '0;
`ifdef UART_PARITY_EN
                    tx_par_nxt   = ^tx_data;
`endif
                end
            end
            S_START: if (tx_end) begin
                tx_cnt_nxt   = '0;
                tx_state_nxt = S_DATA;
                tx_nxt       = tx_shift[0];
                tx_shift_nxt = tx_shift >> 1;
            end
            S_DATA: if (tx_end) begin
                tx_cnt_nxt = '0;
                if (tx_idx == DATA_LAST) begin
                    tx_idx_nxt = '0;
`ifdef UART_PARITY_EN
                    tx_state_nxt = S_PARITY;
                    tx_nxt       = tx_par;
`else
                    tx_state_nxt = S_STOP;
                    tx_nxt       = 1'b1;
`endif
                end else begin
                    tx_idx_nxt   = tx_idx + 4'd1;
                    tx_nxt       = tx_shift[0];
                    tx_shift_nxt = tx_shift >> 1;
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: if (tx_end) begin
                tx_cnt_nxt   = '0;
                tx_state_nxt = S_STOP;
                tx_nxt       = 1'b1;
            end
`endif
            S_STOP: if (tx_end) begin
                tx_cnt_nxt = '0;
                if (tx_idx == STOP_LAST) begin
                    tx_idx_nxt   = '0;
                    tx_state_nxt = S_IDLE;
                end else begin
                    tx_idx_nxt = tx_idx + 4'd1;
                end
            end
            default: tx_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt + CNT_ONE;
        rx_idx_nxt   = rx_idx;
        rx_shift_nxt = rx_shift;
        rx_data_nxt  = rx_data;
        rx_valid_nxt = 1'b0;
        rx_ferr_nxt  = rx_frame_err;
`ifdef UART_PARITY_EN
        rx_pacc_nxt  = rx_pacc;
        rx_perr_nxt  = rx_parity_err;
`endif
        rx_end       = (rx_cnt == CNT_LAST);
        case (rx_state)
            S_IDLE: begin
                rx_cnt_nxt = '0;
                if (rx_prev && !rx_sync) rx_state_nxt = S_START;
            end
            // Half-bit check rejects glitches and aligns later samples to bit centres.
            S_START: if (rx_cnt == CNT_HALF) begin
                rx_cnt_nxt   = '0;
                rx_idx_nxt   = '0;
                rx_state_nxt = rx_sync ? S_IDLE : S_DATA;
            end
            S_DATA: if (rx_end) begin
                rx_cnt_nxt   = '0;
                rx_shift_nxt = {rx_sync, rx_shift[DATA_BITS-1:1]};
                if (rx_idx == DATA_LAST) begin
                    rx_idx_nxt = '0;
`ifdef UART_PARITY_EN
                    rx_state_nxt = S_PARITY;
`else
                    rx_state_nxt = S_STOP;
`endif
                end else begin
                    rx_idx_nxt = rx_idx + 4'd1;
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: if (rx_end) begin
                rx_cnt_nxt   = '0;
                rx_pacc_nxt  = (^rx_shift) ^ rx_sync;
                rx_state_nxt = S_STOP;
            end
`endif
            S_STOP: if (rx_end) begin
                rx_cnt_nxt   = '0;
                rx_valid_nxt = 1'b1;
                rx_data_nxt  = rx_shift;
                rx_ferr_nxt  = !rx_sync;
`ifdef UART_PARITY_EN
                rx_perr_nxt  = rx_pacc;
`endif
                rx_state_nxt = rx_sync ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                rx_cnt_nxt = '0;
                if (rx_sync) rx_state_nxt = S_IDLE;
            end
            default: rx_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state     <= S_IDLE;
            tx_cnt       <= '0;
            tx_idx       <= '0;
            tx_shift     <= '0;
            tx           <= 1'b1;
            rx_state     <= S_IDLE;
            rx_cnt       <= '0;
            rx_idx       <= '0;
            rx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_meta      <= 1'b1;
            rx_sync      <= 1'b1;
            rx_prev      <= 1'b1;
        end else begin
            tx_state     <= tx_state_nxt;
            tx_cnt       <= tx_cnt_nxt;
            tx_idx       <= tx_idx_nxt;
            tx_shift     <= tx_shift_nxt;
            tx           <= tx_nxt;
            rx_state     <= rx_state_nxt;
            rx_cnt       <= rx_cnt_nxt;
            rx_idx       <= rx_idx_nxt;
            rx_shift     <= rx_shift_nxt;
            rx_data      <= rx_data_nxt;
            rx_valid     <= rx_valid_nxt;
            rx_frame_err <= rx_ferr_nxt;
            rx_meta      <= rx;
            rx_sync      <= rx_meta;
            rx_prev      <= rx_sync;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_par        <= 1'b0;
            rx_pacc       <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            tx_par        <= tx_par_nxt;
            rx_pacc       <= rx_pacc_nxt;
            rx_parity_err <= rx_perr_nxt;
        end
    end
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_duplex.sv
// tb/tb_uart_duplex.sv - directed self-checking bench for uart_duplex
module tb_uart_duplex;
`ifdef UART_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int FB = PAR_EN ? 11 : 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_drv = 1'b1;
    logic       loop = 1'b0;
    logic       rx_line;
    logic       tx;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err, rx_parity_err;

    int total = 0;
    int bad = 0;

    logic [7:0] q_d[$];
    logic       q_fe[$];
    logic       q_pe[$];

    assign rx_line = loop ? tx : rx_drv;

    uart_duplex #(.CLK_DIV(8), .DATA_BITS(8), .STOP_BITS(1)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx_line), .tx(tx),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && rx_valid) begin
            q_d.push_back(rx_data);
            q_fe.push_back(rx_frame_err);
            q_pe.push_back(rx_parity_err);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_q();
        q_d.delete();
        q_fe.delete();
        q_pe.delete();
    endtask

    // Frame bits are always built with a parity slot; it is skipped when parity is off.
    task automatic drive_rx_frame(input logic [7:0] w, input logic par, input logic stop);
        logic [10:0] bits;
        bits = {stop, par, w, 1'b0};
        @(negedge clk);
        for (int j = 0; j < 11; j++) begin
            if (j == 9 && !PAR_EN) continue;
            rx_drv = bits[j];
            repeat (8) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        total++; if (rx_frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", rx_frame_err); end
        total++; if (rx_parity_err !== 1'b0) begin bad++; $display("FAIL reset_parity_err: got %b want 0", rx_parity_err); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_tx();
        @(negedge clk);
        tx_data = 8'hF0;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        // cycle 36 is the centre of data bit 3, which is 0 for 0xF0
        repeat (36) @(negedge clk);
        total++; if (tx !== 1'b0) begin bad++; $display("FAIL midtx_bit3: got %b want 0", tx); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL midtx_async_tx: got %b want 1", tx); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL midtx_async_ready: got %b want 1", tx_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_tx_frame(input logic [7:0] w);
        logic [10:0] fr;
        int n;
        int p;
        logic exp_tx, exp_rdy;
        fr = {1'b1, ^w, w, 1'b0};
        n = 0;
        @(negedge clk);
        while (!tx_ready && n < 200) begin @(negedge clk); n++; end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL txframe_wait_ready: got %b want 1", tx_ready); end
        tx_data = w;
        tx_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= FB * 8 + 1; c++) begin
            @(negedge clk);
            if (c <= FB * 8) begin
                p = (c - 1) / 8;
                if (!PAR_EN && p >= 9) p = p + 1;
                exp_tx = fr[p];
                exp_rdy = 1'b0;
            end else begin
                exp_tx = 1'b1;
                exp_rdy = 1'b1;
            end
            total++; if (tx !== exp_tx) begin bad++; $display("FAIL txframe_%h_tx cycle %0d: got %b want %b", w, c, tx, exp_tx); end
            total++; if (tx_ready !== exp_rdy) begin bad++; $display("FAIL txframe_%h_ready cycle %0d: got %b want %b", w, c, tx_ready, exp_rdy); end
            // a request held while busy must be ignored
            if (c == 1) tx_data = 8'h00;
            if (c == 20) tx_valid = 1'b0;
        end
    endtask

    task automatic test_loopback();
        logic [7:0] lw[3];
        int n;
        lw[0] = 8'h00; lw[1] = 8'hFF; lw[2] = 8'h5A;
        clear_q();
        loop = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            @(negedge clk);
            while (!tx_ready && n < 200) begin @(negedge clk); n++; end
            total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL loop_wait_ready %0d: got %b want 1", k, tx_ready); end
            tx_data = lw[k];
            tx_valid = 1'b1;
            @(posedge clk);
            #1 tx_valid = 1'b0;
        end
        repeat (FB * 8 + 30) @(negedge clk);
        total++; if (q_d.size() != 3) begin bad++; $display("FAIL loop_count: got %0d want 3", q_d.size()); end
        for (int k = 0; k < 3; k++) begin
            if (k < q_d.size()) begin
                total++; if (q_d[k] !== lw[k]) begin bad++; $display("FAIL loop_data %0d: got %h want %h", k, q_d[k], lw[k]); end
                total++; if (q_fe[k] !== 1'b0) begin bad++; $display("FAIL loop_frame_err %0d: got %b want 0", k, q_fe[k]); end
                total++; if (q_pe[k] !== 1'b0) begin bad++; $display("FAIL loop_parity_err %0d: got %b want 0", k, q_pe[k]); end
            end
        end
        rx_drv = 1'b1;
        loop = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_glitch();
        clear_q();
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        total++; if (q_d.size() != 0) begin bad++; $display("FAIL glitch_no_strobe: got %0d strobes want 0", q_d.size()); end
        drive_rx_frame(8'h96, ^8'h96, 1'b1);
        repeat (12) @(negedge clk);
        total++; if (q_d.size() != 1) begin bad++; $display("FAIL glitch_after_count: got %0d want 1", q_d.size()); end
        if (q_d.size() > 0) begin
            total++; if (q_d[0] !== 8'h96) begin bad++; $display("FAIL glitch_after_data: got %h want 96", q_d[0]); end
        end
    endtask

    task automatic test_frame_err();
        clear_q();
        drive_rx_frame(8'h3C, 1'b0, 1'b0);
        rx_drv = 1'b0;
        repeat (20) @(negedge clk);
        total++; if (q_d.size() != 1) begin bad++; $display("FAIL ferr_count: got %0d want 1", q_d.size()); end
        if (q_d.size() > 0) begin
            total++; if (q_d[0] !== 8'h3C) begin bad++; $display("FAIL ferr_data: got %h want 3c", q_d[0]); end
            total++; if (q_fe[0] !== 1'b1) begin bad++; $display("FAIL ferr_flag: got %b want 1", q_fe[0]); end
            total++; if (q_pe[0] !== 1'b0) begin bad++; $display("FAIL ferr_parity: got %b want 0", q_pe[0]); end
        end
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        total++; if (q_d.size() != 1) begin bad++; $display("FAIL ferr_break_quiet: got %0d want 1", q_d.size()); end
        drive_rx_frame(8'h81, ^8'h81, 1'b1);
        repeat (12) @(negedge clk);
        total++; if (q_d.size() != 2) begin bad++; $display("FAIL ferr_recover_count: got %0d want 2", q_d.size()); end
        if (q_d.size() > 1) begin
            total++; if (q_d[1] !== 8'h81) begin bad++; $display("FAIL ferr_recover_data: got %h want 81", q_d[1]); end
            total++; if (q_fe[1] !== 1'b0) begin bad++; $display("FAIL ferr_recover_flag: got %b want 0", q_fe[1]); end
        end
    endtask

    task automatic test_parity();
        logic exp_pe;
        exp_pe = PAR_EN;
        clear_q();
        drive_rx_frame(8'h01, 1'b0, 1'b1);
        repeat (12) @(negedge clk);
        total++; if (q_d.size() != 1) begin bad++; $display("FAIL parity_count: got %0d want 1", q_d.size()); end
        if (q_d.size() > 0) begin
            total++; if (q_d[0] !== 8'h01) begin bad++; $display("FAIL parity_data: got %h want 01", q_d[0]); end
            total++; if (q_pe[0] !== exp_pe) begin bad++; $display("FAIL parity_flag: got %b want %b", q_pe[0], exp_pe); end
            total++; if (q_fe[0] !== 1'b0) begin bad++; $display("FAIL parity_frame_err: got %b want 0", q_fe[0]); end
        end
        total++; if (rx_parity_err !== exp_pe) begin bad++; $display("FAIL parity_held: got %b want %b", rx_parity_err, exp_pe); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_tx();
        test_tx_frame(8'hA5);
        test_loopback();
        test_glitch();
        test_frame_err();
        test_parity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
